// File: rtl/stream_rx_fifo_pkg.sv
// Shared constants and helpers for the valid-only stream receive FIFO.
package stream_rx_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_DEPTH      = 16;
  localparam int DROP_CNT_W     = 16;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_rx_fifo_if.sv
// Stream bundle: valid-only producer side plus ready/valid consumer side.
interface stream_rx_fifo_if #(
  parameter int DATA_WIDTH = stream_rx_pkg::DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  datavalid_in;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  datavalid_out;

  modport slave (
    input  data_in, datavalid_in, ready_in,
    output data_out, datavalid_out
  );

  modport master (
    output data_in, datavalid_in, ready_in,
    input  data_out, datavalid_out
  );
endinterface

// File: rtl/stream_rx_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module stream_rx_fifo_mem #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/stream_rx_fifo.sv
// Receive FIFO: absorbs an unstallable valid-only stream, re-presents it over ready/valid.
// Optional STREAM_RX_DROP_CNT_EN adds a saturating drop_count output.
module stream_rx_fifo
  import stream_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  stream_rx_fifo_if.slave          s_if,
  input  logic                     ovf_clear,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     overflow_sticky
`ifdef STREAM_RX_DROP_CNT_EN
  , output logic [DROP_CNT_W-1:0]  drop_count
`endif
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  sticky_q, sticky_d;
  logic                  full, empty, push, pop, drop;
  logic [DATA_WIDTH-1:0] rd_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && s_if.ready_in;
  // A pop frees a slot in the same edge, so a full FIFO still accepts.
  assign push  = s_if.datavalid_in && (!full || pop);
  assign drop  = s_if.datavalid_in && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d    = drop;
    // A drop in the same cycle as a clear keeps the sticky set.
    sticky_d = drop ? 1'b1 : (ovf_clear ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  stream_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (s_if.data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

`ifdef STREAM_RX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clear)
      drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
    else if (drop && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  assign s_if.datavalid_out = !empty;
  assign s_if.data_out      = empty ? '0 : rd_data;
  assign level              = count_q;
  assign overflow           = ovf_q;
  assign overflow_sticky    = sticky_q;

endmodule

// File: tb/tb_stream_rx_fifo.sv
// Scoreboard bench for stream_rx_fifo: a queue model checked every cycle.
module tb_stream_rx_fifo;
  import stream_rx_pkg::*;

  localparam int DW = 12;
  localparam int DP = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        ovf_clear;
  logic [4:0]  level;
  logic        overflow;
  logic        overflow_sticky;
`ifdef STREAM_RX_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clock = ~clock;

  stream_rx_fifo_if #(.DATA_WIDTH(DW)) s_if ();

  stream_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clock           (clock),
    .reset           (reset),
    .s_if            (s_if.slave),
    .ovf_clear       (ovf_clear),
    .level           (level),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky)
`ifdef STREAM_RX_DROP_CNT_EN
    , .drop_count    (drop_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf, m_sticky;
  int            m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Compare outputs against the model, then advance both by one clock edge.
  task automatic tick();
    bit pop, push, drop;
    chk("level", 32'(level), 32'(mq.size()));
    chk("valid", 32'(s_if.datavalid_out), 32'(mq.size() != 0));
    chk("data", 32'(s_if.data_out), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("sticky", 32'(overflow_sticky), 32'(m_sticky));
`ifdef STREAM_RX_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_count), 32'(m_drop));
`endif
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_sticky = 0; m_drop = 0;
    end else begin
      pop  = (mq.size() != 0) && s_if.ready_in;
      push = s_if.datavalid_in && ((mq.size() < DP) || pop);
      drop = s_if.datavalid_in && !push;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(s_if.data_in);
      m_ovf    = drop;
      m_sticky = drop ? 1'b1 : (ovf_clear ? 1'b0 : m_sticky);
      if (ovf_clear)                  m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 65535) m_drop++;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    s_if.datavalid_in = 1'b1;
    s_if.data_in      = w;
    tick();
    s_if.datavalid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ovf_clear = 1'b0;
    s_if.data_in = '0; s_if.datavalid_in = 1'b0; s_if.ready_in = 1'b0;
    m_ovf = 0; m_sticky = 0; m_drop = 0;
    @(negedge clock);
    tick(); tick();
    reset = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(s_if.datavalid_out), 32'd0);

    // Three words buffered, then drained in order.
    for (int i = 1; i <= 3; i++) push_word(DW'(i));
    chk("t1_level", 32'(level), 32'd3);
    chk("t1_head", 32'(s_if.data_out), 32'h001);
    s_if.ready_in = 1'b1;
    repeat (4) tick();
    s_if.ready_in = 1'b0;
    chk("t1_empty", 32'(s_if.datavalid_out), 32'd0);
    chk("t1_zero", 32'(s_if.data_out), 32'd0);

    // Fill, then overflow with 0xABC.
    for (int i = 0; i < DP; i++) push_word(DW'(12'h100 + i));
    push_word(12'hABC);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_sticky", 32'(overflow_sticky), 32'd1);
    chk("t2_level", 32'(level), 32'd16);
`ifdef STREAM_RX_DROP_CNT_EN
    chk("t2_drop_cnt", 32'(drop_count), 32'd1);
`endif
    tick();
    chk("t2_ovf_pulse", 32'(overflow), 32'd0);

    // Push while full with a simultaneous pop.
    s_if.ready_in = 1'b1;
    push_word(12'h555);
    s_if.ready_in = 1'b0;
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_level", 32'(level), 32'd16);
    s_if.ready_in = 1'b1;
    repeat (15) tick();
    chk("t3_555", 32'(s_if.data_out), 32'h555);
    repeat (2) tick();
    chk("t3_drained", 32'(level), 32'd0);

    // Sustained push/pop of 100 words with pointer wrap.
    for (int i = 0; i < 100; i++) begin
      push_word(DW'(i + 12'h200));
      chk("t4_level_le1", 32'(level <= 5'd1), 32'd1);
    end
    repeat (2) tick();
    s_if.ready_in = 1'b0;

    // Reset mid-stream with seven stored words.
    for (int i = 0; i < 7; i++) push_word(DW'(12'h300 + i));
    chk("t5_level7", 32'(level), 32'd7);
    reset = 1'b1;
    push_word(12'h3FF);
    reset = 1'b0;
    chk("t5_level0", 32'(level), 32'd0);
    chk("t5_valid0", 32'(s_if.datavalid_out), 32'd0);
    chk("t5_ovf0", 32'(overflow), 32'd0);
    chk("t5_sticky0", 32'(overflow_sticky), 32'd0);
    push_word(12'h123);
    chk("t5_head", 32'(s_if.data_out), 32'h123);
    s_if.ready_in = 1'b1;
    repeat (3) tick();
    s_if.ready_in = 1'b0;

    // Sticky: clear racing a drop, then clear alone.
    for (int i = 0; i < DP; i++) push_word(DW'(12'h400 + i));
    push_word(12'hDDD);
    ovf_clear = 1'b1;
    push_word(12'hEEE);
    ovf_clear = 1'b0;
    chk("t6_sticky_held", 32'(overflow_sticky), 32'd1);
`ifdef STREAM_RX_DROP_CNT_EN
    chk("t6_drop_cnt1", 32'(drop_count), 32'd1);
`endif
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("t6_sticky_clr", 32'(overflow_sticky), 32'd0);
    s_if.ready_in = 1'b1;
    repeat (DP + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_rx_fifo.md
# stream_rx_fifo

Receive-side buffer for the team's valid-only sample stream (`data_in`/`datavalid_in`, no backpressure). It absorbs words that arrive whenever the producer asserts valid and re-presents them to a downstream consumer over a ready/valid handshake. It sits between any valid-only stream producer and logic that must stall, such as bus masters or packetisers. Words that arrive while the buffer is full are dropped and flagged.

## Interface
- `DATA_WIDTH`, 12: word width.
- `DEPTH`, 16: FIFO entries; must be a power of 2 and ≥ 2.
- `clock` in 1: single clock domain; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in DATA_WIDTH: incoming word.
- `datavalid_in` in 1: `data_in` is valid this cycle; cannot be stalled.
- `ready_in` in 1: consumer accepts `data_out` this cycle.
- `ovf_clear` in 1: clears `overflow_sticky`.
- `data_out` out DATA_WIDTH: head word; forced to 0 when empty.
- `datavalid_out` out 1: FIFO non-empty; `data_out` is valid.
- `level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out 1: one-cycle pulse when a word is dropped.
- `overflow_sticky` out 1: set on any drop; held until cleared.

## Operation
- Storage: DEPTH-entry array with write and read pointers of ADDR_W = $clog2(DEPTH) bits. Pointers wrap modulo DEPTH naturally.
- Occupancy: separate `count` register of ADDR_W+1 bits; `level = count`. `full` when count == DEPTH; `empty` when count == 0.
- Pop: occurs when `datavalid_out && ready_in`. The read pointer increments. `ready_in` while empty has no effect.
- Push: occurs when `datavalid_in && (!full || pop)`. The word is written at the write pointer, which then increments.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Drop: `datavalid_in && full && !pop`. The word is discarded, pointers are unchanged, `overflow` pulses on the next cycle, and `overflow_sticky` sets.
- Full with simultaneous pop: the push is accepted, count stays DEPTH, and no overflow is raised.
- Empty with simultaneous push: no bypass; the word becomes visible the next cycle.
- `ovf_clear` and a drop in the same cycle: the set wins and the sticky stays 1.
- `datavalid_out = !empty`. `data_out = empty ? 0 : mem[rd_ptr]`.
- Ordering: strict FIFO, with no reordering and no duplication.
- Reset: pointers 0, count 0, `datavalid_out` 0, `data_out` 0, `level` 0, `overflow` 0, `overflow_sticky` 0.
  - Array contents are not reset.
  - Reset mid-operation discards all stored words. The first push after reset deasserts is accepted normally.

## Timing
- Latency from push (edge N) to `datavalid_out`: high after edge N, i.e. visible in cycle N+1 (1 cycle).
- Pop at edge N: the next head (or empty) is presented in cycle N+1.
- Throughput: 1 word/cycle sustained in and out simultaneously, at any level.
- `overflow` is registered: it is high in the cycle after the dropped input, for exactly 1 cycle per dropped word.
- `level` is registered and reflects all pushes and pops up to the last edge.
- No combinational path from `datavalid_in` or `data_in` to any output.
- `ready_in` → `data_out` is not combinational. The head changes only at the clock edge.

## Configuration
- `STREAM_RX_DROP_CNT_EN`:
  - Defined: adds output `drop_count` [15:0].
    - Reset to 0; increments on every dropped word.
    - Saturates at 16'hFFFF.
    - Cleared by `ovf_clear`; a same-cycle drop gives a result of 1.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `stream_rx_pkg`:
  - default `DATA_WIDTH` and `DEPTH` constants;
  - `DROP_CNT_W` = 16;
  - function `addr_w(depth)` returning $clog2(depth).
- Sub-module `stream_rx_fifo_mem`: simple dual-port array with synchronous write and asynchronous read (distributed RAM), parameterised by `DATA_WIDTH` and `DEPTH`.
- Top `stream_rx_fifo` holds the pointers, count, flags, optional drop counter and output masking.

## Test plan
- Reset, then push 0x001..0x003 on consecutive cycles with `ready_in`=0.
  - Expect `level`=3 and `data_out`=0x001.
  - Then hold `ready_in`=1: expect 0x001, 0x002, 0x003 on three cycles, then `datavalid_out`=0 and `data_out`=0.
- Fill DEPTH=16 with `ready_in`=0, then push 0xABC.
  - Expect `overflow` high for 1 cycle, `overflow_sticky`=1, `level`=16 and 0xABC never output.
  - With the macro on, expect `drop_count`=1.
- At full, push 0x555 with `ready_in`=1 in the same cycle.
  - Expect no overflow and `level` still 16.
  - 0x555 emerges 16th after the pop.
- Continuous push and pop of 100 incrementing words from empty.
  - Expect output identical and in order, one cycle behind input.
  - `level` ≤ 1 throughout; wrap-around exercised.
- Assert `reset` with `level`=7 mid-stream.
  - Next cycle: `level`=0, `datavalid_out`=0, flags 0.
  - A subsequent push of 0x123 appears alone.
- Set the sticky, then pulse `ovf_clear` and a drop in the same cycle: sticky stays 1. Pulse `ovf_clear` alone: sticky goes to 0.
